// File: rtl/lane_commit_tracker.sv
// In-order vector commit tracker: records issued vector instructions, gathers
// per-lane completion pulses and requests commit of the oldest complete entry.
// Optional macro LANE_COMMIT_ERR_EN adds a sticky O_Err for unmatched or duplicate pulses.
module lane_commit_tracker #(
  parameter int NUM_LANE    = 4,
  parameter int NUM_ENTRY   = 8,
  parameter int WIDTH_ISSUE = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Issue,
  input  logic [WIDTH_ISSUE-1:0]          I_Issue_No,
  input  logic [NUM_LANE-1:0]             I_En_Lane,
  input  logic [NUM_LANE-1:0]             I_Lane_Done,
  input  logic [NUM_LANE*WIDTH_ISSUE-1:0] I_Lane_No,
  output logic                            O_Commit_Req,
  output logic [WIDTH_ISSUE-1:0]          O_Commit_No,
  input  logic                            I_Commit_Ack,
  output logic                            O_Full,
  output logic                            O_Empty,
  output logic [$clog2(NUM_ENTRY):0]      O_Num
`ifdef LANE_COMMIT_ERR_EN
  ,
  output logic                            O_Err
`endif
);

  localparam int PW = $clog2(NUM_ENTRY);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]              r_head;
  logic [PW:0]              r_tail;
  logic [NUM_ENTRY-1:0]     r_valid;
  logic [WIDTH_ISSUE-1:0]   r_issue_no [NUM_ENTRY];
  logic [NUM_LANE-1:0]      r_en_lane  [NUM_ENTRY];
  logic [NUM_LANE-1:0]      r_done     [NUM_ENTRY];
  logic [WIDTH_ISSUE-1:0]   r_last_no;

  logic [PW-1:0]            w_head_idx;
  logic [PW-1:0]            w_tail_idx;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_alloc;
  logic                     w_commit;
  logic                     w_head_valid;
  logic                     w_head_complete;
  logic [NUM_LANE-1:0]      w_set [NUM_ENTRY];
  logic [PW-1:0]            w_idx;
  logic                     w_found;
`ifdef LANE_COMMIT_ERR_EN
  logic                     w_err;
  logic                     r_err;
`endif

  assign w_head_idx      = r_head[PW-1:0];
  assign w_tail_idx      = r_tail[PW-1:0];
  assign w_empty         = (r_head == r_tail);
  assign w_full          = (w_head_idx == w_tail_idx) && (r_head[PW] != r_tail[PW]);
  assign w_head_valid    = r_valid[w_head_idx];
  assign w_head_complete = ((r_done[w_head_idx] & r_en_lane[w_head_idx]) == r_en_lane[w_head_idx]);
  assign w_alloc         = I_Issue && !w_full;
  assign w_commit        = I_Commit_Ack && O_Commit_Req;

  assign O_Commit_Req = w_head_valid && w_head_complete;
  assign O_Commit_No  = w_head_valid ? r_issue_no[w_head_idx] : r_last_no;
  assign O_Full       = w_full;
  assign O_Empty      = w_empty;
  assign O_Num        = r_tail - r_head;
`ifdef LANE_COMMIT_ERR_EN
  assign O_Err        = r_err;
`endif

  // Each lane walks from head toward tail; the first valid, enabled entry with a
  // matching issue number takes the pulse. Same-cycle allocations are not yet valid.
  always_comb begin
    for (int e = 0; e < NUM_ENTRY; e++) begin
      w_set[e] = '0;
    end
    w_idx   = '0;
    w_found = 1'b0;
`ifdef LANE_COMMIT_ERR_EN
    w_err   = 1'b0;
`endif
    for (int k = 0; k < NUM_LANE; k++) begin
      w_found = 1'b0;
      if (I_Lane_Done[k]) begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
          w_idx = w_head_idx + PW'(i);
          if (!w_found && r_valid[w_idx] && r_en_lane[w_idx][k] &&
              (r_issue_no[w_idx] == I_Lane_No[k*WIDTH_ISSUE +: WIDTH_ISSUE])) begin
            w_found           = 1'b1;
            w_set[w_idx][k]   = 1'b1;
`ifdef LANE_COMMIT_ERR_EN
            if (r_done[w_idx][k]) w_err = 1'b1;
`endif
          end
        end
`ifdef LANE_COMMIT_ERR_EN
        if (!w_found) w_err = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_valid   <= '0;
      r_last_no <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_issue_no[e] <= '0;
        r_en_lane[e]  <= '0;
        r_done[e]     <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_done[e] <= r_done[e] | w_set[e];
      end
      if (w_head_valid) r_last_no <= r_issue_no[w_head_idx];
      // Clearing on commit overrides any pulse landing on the retiring head.
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= '0;
        r_head              <= r_head + (PW+1)'(1);
      end
      if (w_alloc) begin
        r_valid[w_tail_idx]    <= 1'b1;
        r_issue_no[w_tail_idx] <= I_Issue_No;
        r_en_lane[w_tail_idx]  <= I_En_Lane;
        r_done[w_tail_idx]     <= '0;
        r_tail                 <= r_tail + (PW+1)'(1);
      end
    end
  end

`ifdef LANE_COMMIT_ERR_EN
  always_ff @(posedge clock) begin
    if (!reset) r_err <= 1'b0;
    else if (w_err) r_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_lane_commit_tracker.sv
// Directed bench for lane_commit_tracker: expected commit numbers are queued at
// issue and popped when the tracker requests commit.
module tb_lane_commit_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Issue;
  logic [7:0]  I_Issue_No;
  logic [3:0]  I_En_Lane;
  logic [3:0]  I_Lane_Done;
  logic [31:0] I_Lane_No;
  logic        O_Commit_Req;
  logic [7:0]  O_Commit_No;
  logic        I_Commit_Ack;
  logic        O_Full;
  logic        O_Empty;
  logic [3:0]  O_Num;
`ifdef LANE_COMMIT_ERR_EN
  logic        O_Err;
`endif

  int total = 0;
  int bad   = 0;
  int m_num = 0;
  logic [7:0] exp_q[$];

  lane_commit_tracker #(.NUM_LANE(4), .NUM_ENTRY(8), .WIDTH_ISSUE(8)) dut (
    .clock(clock), .reset(reset),
    .I_Issue(I_Issue), .I_Issue_No(I_Issue_No), .I_En_Lane(I_En_Lane),
    .I_Lane_Done(I_Lane_Done), .I_Lane_No(I_Lane_No),
    .O_Commit_Req(O_Commit_Req), .O_Commit_No(O_Commit_No),
    .I_Commit_Ack(I_Commit_Ack),
    .O_Full(O_Full), .O_Empty(O_Empty), .O_Num(O_Num)
`ifdef LANE_COMMIT_ERR_EN
    , .O_Err(O_Err)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_issue(input logic [7:0] no, input logic [3:0] en);
    I_Issue    = 1'b1;
    I_Issue_No = no;
    I_En_Lane  = en;
    if (m_num < 8) begin
      exp_q.push_back(no);
      m_num++;
    end
    step();
    I_Issue = 1'b0;
  endtask

  task automatic lane_pulse(input logic [3:0] mask, input logic [31:0] nos);
    I_Lane_Done = mask;
    I_Lane_No   = nos;
    step();
    I_Lane_Done = '0;
  endtask

  // scoreboard pop: the head request must be up and carry the oldest issued number
  task automatic do_commit();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL commit_q_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("commit_req", {31'b0, O_Commit_Req}, 32'd1);
      chk("commit_no", {24'b0, O_Commit_No}, {24'b0, e});
      m_num--;
    end
    I_Commit_Ack = 1'b1;
    step();
    I_Commit_Ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; I_Issue = 1'b0; I_Issue_No = '0; I_En_Lane = '0;
    I_Lane_Done = '0; I_Lane_No = '0; I_Commit_Ack = 1'b0;
    step(); step();
    chk("rst_empty", {31'b0, O_Empty}, 32'd1);
    chk("rst_full", {31'b0, O_Full}, 32'd0);
    chk("rst_num", {28'b0, O_Num}, 32'd0);
    chk("rst_req", {31'b0, O_Commit_Req}, 32'd0);
    chk("rst_no", {24'b0, O_Commit_No}, 32'd0);
    reset = 1'b1;
    step();

    // basic: partial lane mask completes in one cycle of pulses
    do_issue(8'h05, 4'b1011);
    chk("b_req_pending", {31'b0, O_Commit_Req}, 32'd0);
    chk("b_num", {28'b0, O_Num}, 32'd1);
    lane_pulse(4'b1011, {4{8'h05}});
    do_commit();
    chk("b_empty", {31'b0, O_Empty}, 32'd1);

    // younger completes first, must wait for head
    do_issue(8'h10, 4'b1111);
    do_issue(8'h11, 4'b1111);
    lane_pulse(4'b1111, {4{8'h11}});
    chk("ord_no_req", {31'b0, O_Commit_Req}, 32'd0);
    lane_pulse(4'b1111, {4{8'h10}});
    do_commit();
    do_commit();
    chk("ord_empty", {31'b0, O_Empty}, 32'd1);

    // fill, drop on full, drain in order
    for (int i = 0; i < 8; i++) do_issue(8'h40 + 8'(i), 4'b0001);
    chk("fill_full", {31'b0, O_Full}, 32'd1);
    chk("fill_num", {28'b0, O_Num}, 32'd8);
    do_issue(8'h48, 4'b0001);
    chk("drop_num", {28'b0, O_Num}, 32'd8);
    for (int i = 0; i < 8; i++) lane_pulse(4'b0001, {24'b0, 8'h40 + 8'(i)});
    for (int i = 0; i < 8; i++) do_commit();
    chk("drain_empty", {31'b0, O_Empty}, 32'd1);

    // wrapped pointers, lanes hitting different entries in one cycle
    for (int i = 0; i < 4; i++) do_issue(8'h50 + 8'(i), 4'b0011);
    lane_pulse(4'b0011, {16'b0, 8'h52, 8'h53});
    lane_pulse(4'b0011, {16'b0, 8'h53, 8'h52});
    lane_pulse(4'b0011, {4{8'h51}});
    chk("wrap_head_wait", {31'b0, O_Commit_Req}, 32'd0);
    lane_pulse(4'b0011, {4{8'h50}});
    for (int i = 0; i < 4; i++) do_commit();
    chk("wrap_empty", {31'b0, O_Empty}, 32'd1);

    // full + ack + issue same cycle: issue dropped
    for (int i = 0; i < 8; i++) do_issue(8'h60 + 8'(i), 4'b0000);
    chk("f2_full", {31'b0, O_Full}, 32'd1);
    chk("f2_req", {31'b0, O_Commit_Req}, 32'd1);
    chk("f2_no", {24'b0, O_Commit_No}, {24'b0, exp_q[0]});
    I_Issue = 1'b1; I_Issue_No = 8'h68; I_En_Lane = 4'b0000; I_Commit_Ack = 1'b1;
    void'(exp_q.pop_front());
    m_num--;
    step();
    I_Issue = 1'b0; I_Commit_Ack = 1'b0;
    chk("f2_num7", {28'b0, O_Num}, 32'd7);
    chk("f2_not_full", {31'b0, O_Full}, 32'd0);
    do_issue(8'h69, 4'b0000);
    chk("f2_num8", {28'b0, O_Num}, 32'd8);
    for (int i = 0; i < 8; i++) do_commit();
    chk("f2_empty", {31'b0, O_Empty}, 32'd1);

    // no enabled lanes: complete on allocation; request holds without ack
    do_issue(8'h20, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {31'b0, O_Commit_Req}, 32'd1);
      chk("hold_no", {24'b0, O_Commit_No}, 32'h20);
      step();
    end
    do_commit();
    chk("hold_last_no", {24'b0, O_Commit_No}, 32'h20);

    // allocate + commit same cycle keeps count
    do_issue(8'h30, 4'b0000);
    chk("ac_num_before", {28'b0, O_Num}, 32'd1);
    chk("ac_no", {24'b0, O_Commit_No}, 32'h30);
    I_Issue = 1'b1; I_Issue_No = 8'h31; I_En_Lane = 4'b0000; I_Commit_Ack = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h31);
    step();
    I_Issue = 1'b0; I_Commit_Ack = 1'b0;
    chk("ac_num_after", {28'b0, O_Num}, 32'd1);
    do_commit();
    chk("ac_empty", {31'b0, O_Empty}, 32'd1);

`ifdef LANE_COMMIT_ERR_EN
    chk("err_clean", {31'b0, O_Err}, 32'd0);
    lane_pulse(4'b0001, {24'b0, 8'h33});
    chk("err_set", {31'b0, O_Err}, 32'd1);
    step(); step();
    chk("err_sticky", {31'b0, O_Err}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("err_reset", {31'b0, O_Err}, 32'd0);
`endif

    // reset mid-operation discards entries
    I_Issue = 1'b1; I_Issue_No = 8'h70; I_En_Lane = 4'b0000;
    step();
    I_Issue = 1'b0;
    chk("mid_req", {31'b0, O_Commit_Req}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_req", {31'b0, O_Commit_Req}, 32'd0);
    chk("mid_rst_empty", {31'b0, O_Empty}, 32'd1);
    chk("mid_rst_num", {28'b0, O_Num}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
